// File: rtl/vbuffer_fill_pkg.sv
// Shared video definitions: fill FSM encoding and line-buffer geometry defaults
// so the fill controller and the line buffer agree on sizes.
package vbuffer_fill_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } fill_state_t;

  localparam int AWIDTH_DEF  = 2;
  localparam int BPP_DEF     = 6;
  localparam int PSIZE_DEF   = 4;
  localparam int MAWIDTH_DEF = 16;

endpackage

// File: rtl/vbuffer_fill.sv
// Line-buffer write-side controller: on LineStart, fetches PSIZE pixels from video
// memory via req/ack and writes them to buffer addresses 0..PSIZE-1, then pulses Done.
module vbuffer_fill
  import vbuffer_fill_pkg::*;
#(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int BPP     = BPP_DEF,
  parameter int PSIZE   = PSIZE_DEF,
  parameter int MAWIDTH = MAWIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               LineStart,
  input  logic [MAWIDTH-1:0] LineBase,
  output logic               MemReq,
  output logic [MAWIDTH-1:0] MemAddr,
  input  logic               MemAck,
  input  logic [BPP-1:0]     MemData,
  output logic               Write,
  output logic [AWIDTH-1:0]  WriteAddress,
  output logic [BPP-1:0]     DataOut,
  output logic               Busy,
  output logic               Done,
  output logic               Overrun
);

  localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(PSIZE - 1);

  fill_state_t        state, state_nxt;
  logic [AWIDTH-1:0]  count, count_nxt;
  logic [MAWIDTH-1:0] mem_addr_nxt;
  logic [AWIDTH-1:0]  waddr_nxt;
  logic [BPP-1:0]     data_nxt;
  logic               req_nxt, write_nxt, busy_nxt, done_nxt, overrun_nxt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      count        <= '0;
      MemReq       <= 1'b0;
      MemAddr      <= '0;
      Write        <= 1'b0;
      WriteAddress <= '0;
      DataOut      <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      MemReq       <= req_nxt;
      MemAddr      <= mem_addr_nxt;
      Write        <= write_nxt;
      WriteAddress <= waddr_nxt;
      DataOut      <= data_nxt;
      Busy         <= busy_nxt;
      Done         <= done_nxt;
      Overrun      <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    mem_addr_nxt = MemAddr;
    waddr_nxt    = WriteAddress;
    data_nxt     = DataOut;
    // A start request while a line is in flight is flagged and otherwise dropped.
    overrun_nxt  = LineStart && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (LineStart) begin
          mem_addr_nxt = LineBase;
          count_nxt    = '0;
          state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (MemAck) begin
          data_nxt  = MemData;
          waddr_nxt = count;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (count == LAST_PIX) begin
          state_nxt = S_DONE;
        end else begin
          count_nxt    = count + AWIDTH'(1);
          mem_addr_nxt = MemAddr + MAWIDTH'(1);
          state_nxt    = S_REQ;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so every output leaves a flop.
    req_nxt   = (state_nxt == S_REQ);
    write_nxt = (state_nxt == S_WRITE);
    done_nxt  = (state_nxt == S_DONE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_vbuffer_fill.sv
// Directed bench for vbuffer_fill: memory responder plus scoreboard of expected buffer writes.
module tb_vbuffer_fill;
  import vbuffer_fill_pkg::*;

  localparam int AW = AWIDTH_DEF;
  localparam int BW = BPP_DEF;
  localparam int PS = PSIZE_DEF;
  localparam int MW = MAWIDTH_DEF;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          LineStart;
  logic [MW-1:0] LineBase;
  logic          MemReq;
  logic [MW-1:0] MemAddr;
  logic          MemAck;
  logic [BW-1:0] MemData;
  logic          Write;
  logic [AW-1:0] WriteAddress;
  logic [BW-1:0] DataOut;
  logic          Busy;
  logic          Done;
  logic          Overrun;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [BW-1:0] data;
    logic [MW-1:0] maddr;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  vbuffer_fill #(.AWIDTH(AW), .BPP(BW), .PSIZE(PS), .MAWIDTH(MW)) dut (
    .Clk(Clk), .Reset(Reset), .LineStart(LineStart), .LineBase(LineBase),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .Write(Write), .WriteAddress(WriteAddress), .DataOut(DataOut),
    .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [BW-1:0] mem_fn(input logic [MW-1:0] a);
    return BW'(a[5:0] + 6'h11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memreq"}, 32'(MemReq), 32'd0);
    chk({tag, "_memaddr"}, 32'(MemAddr), 32'd0);
    chk({tag, "_write"}, 32'(Write), 32'd0);
    chk({tag, "_waddr"}, 32'(WriteAddress), 32'd0);
    chk({tag, "_dataout"}, 32'(DataOut), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_overrun"}, 32'(Overrun), 32'd0);
  endtask

  // Cycle c is the clock period after edge c-1; LineStart is sampled at edge 0.
  task automatic run_fetch(input logic [MW-1:0] base, input int lat, input int ovr,
                           input int abort_n, input int exp_done);
    exp_t e;
    int nw     = 0;
    int reqc   = 0;
    int done_c = -1;
    for (int i = 0; i < PS; i++) begin
      e.waddr = AW'(i);
      e.maddr = base + MW'(i);
      e.data  = mem_fn(e.maddr);
      sb.push_back(e);
    end
    @(negedge Clk);
    LineBase  = base;
    LineStart = 1'b1;
    MemAck    = 1'b0;
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge Clk);
      LineStart = (c == ovr);
      if (c == ovr) LineBase = 16'hDEAD;
      MemAck = 1'b0;
      chk("overrun", 32'(Overrun), 32'(c == ovr + 1));
      chk("req_write_excl", 32'(MemReq & Write), 32'd0);
      if (Done) begin
        done_c = c;
        chk("done_cycle", 32'(c), 32'(exp_done));
        chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
        chk("busy_in_done", 32'(Busy), 32'd1);
      end else if (Write) begin
        chk("busy_in_write", 32'(Busy), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("write_addr", 32'(WriteAddress), 32'(e.waddr));
          chk("data_out", 32'(DataOut), 32'(e.data));
          chk("req_cycles", 32'(reqc), 32'(lat + 1));
        end
        nw++;
        reqc = 0;
      end else if (MemReq) begin
        chk("busy_in_req", 32'(Busy), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("mem_addr", 32'(MemAddr), 32'(sb[0].maddr));
          if (nw > 0) chk("waddr_hold", 32'(WriteAddress), 32'(nw - 1));
          if (nw == abort_n) begin
            #2 Reset = 1'b1;
            #1 chk_all_zero("abort");
            sb.delete();
            @(negedge Clk);
            Reset   = 1'b0;
            MemAck  = 1'b1;
            MemData = 6'h3F;
            for (int k = 0; k < 3; k++) begin
              @(negedge Clk);
              chk("spurious_ack_write", 32'(Write), 32'd0);
              chk("spurious_ack_req", 32'(MemReq), 32'd0);
              chk("spurious_ack_busy", 32'(Busy), 32'd0);
            end
            MemAck = 1'b0;
            return;
          end
          reqc++;
          if (reqc == lat + 1) begin
            MemAck  = 1'b1;
            MemData = sb[0].data;
          end
        end
      end else begin
        chk("stalled_fsm", 32'd1, 32'd0);
      end
    end
    if (done_c < 0) chk("done_timeout", 32'd0, 32'd1);
    LineStart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      chk("idle_busy", 32'(Busy), 32'd0);
      chk("idle_done", 32'(Done), 32'd0);
      chk("idle_memreq", 32'(MemReq), 32'd0);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    LineStart = 1'b0;
    LineBase  = '0;
    MemAck    = 1'b0;
    MemData   = '0;
    #2 chk_all_zero("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_reset_busy", 32'(Busy), 32'd0);
    chk("post_reset_memreq", 32'(MemReq), 32'd0);

    run_fetch(16'h0100, 0, -1, -1, 9);
    run_fetch(16'h1230, 3, -1, -1, 21);
    run_fetch(16'h0400, 0, 4, -1, 9);
    run_fetch(16'hFFFE, 1, -1, -1, 13);
    run_fetch(16'h0300, 0, -1, 2, 0);
    run_fetch(16'h0200, 0, -1, -1, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vbuffer_fill.md
Name: vbuffer_fill

Overview:
- Write-side controller for the pixel line buffer; it is the producer that feeds the buffer's Write/WriteAddress/DataIn port.
- On each LineStart pulse it fetches PSIZE pixels from video memory over a req/ack handshake, starting at LineBase.
- It writes each pixel into consecutive buffer addresses 0..PSIZE-1, then signals Done.
- It sits between the video memory arbiter and the line buffer, and is triggered by the video timing generator ahead of active scan-out.

Parameters:
- AWIDTH, 2, buffer address width
- BPP, 6, bits per pixel
- PSIZE, 4, pixels per fetch (PSIZE <= 2**AWIDTH)
- MAWIDTH, 16, video memory address width

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- LineStart  input  1  one-cycle pulse, start a line fetch
- LineBase  input  MAWIDTH  memory address of first pixel; sampled only when LineStart is accepted
- MemReq  output  1  memory read request
- MemAddr  output  MAWIDTH  read address, stable while MemReq=1
- MemAck  input  1  read complete; MemData valid in the same cycle
- MemData  input  BPP  read data
- Write  output  1  buffer write strobe
- WriteAddress  output  AWIDTH  buffer write address
- DataOut  output  BPP  buffer write data
- Busy  output  1  fetch in progress
- Done  output  1  one-cycle pulse, line fetch complete
- Overrun  output  1  one-cycle pulse, LineStart arrived while Busy

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time): FSM=IDLE, pixel count=0, and every output is 0.
  - A request in flight is abandoned; the memory side must tolerate a dropped request.
- FSM states: IDLE, REQ, WRITE, DONE.
- IDLE:
  - Busy=0.
  - LineStart=1: latch MemAddr<=LineBase, count<=0, go to REQ.
  - MemAck is ignored.
- REQ:
  - MemReq=1, Busy=1, MemAddr held stable.
  - On an edge with MemAck=1: capture MemData into DataOut, set WriteAddress<=count, go to WRITE.
  - Otherwise stay in REQ with no timeout.
  - An ack may arrive in the first REQ cycle.
- WRITE:
  - Write=1 for exactly one cycle, MemReq=0.
  - If count==PSIZE-1, go to DONE.
  - Otherwise count<=count+1, MemAddr<=MemAddr+1, go to REQ.
- DONE:
  - Done=1 for one cycle, Busy=1.
  - Next state is IDLE.
  - LineStart sampled in DONE counts as an overrun and is dropped.
- Throughput and latency: minimum 2 cycles per pixel.
  - With zero-wait ack and LineStart sampled at edge 0: Write is high in cycles 2,4,...,2+2(PSIZE-1); Done is high in cycle 2+2·PSIZE-1.
- MemAddr arithmetic is modulo 2**MAWIDTH and wraps silently.
- WriteAddress never exceeds PSIZE-1.
- LineStart while Busy=1 (REQ/WRITE/DONE):
  - Overrun=1 next cycle for one cycle.
  - The current fetch continues unaffected; LineBase is not re-sampled.
- MemAck outside REQ is ignored, with no Write and no state change.
- Write and MemReq are never high in the same cycle.
- DataOut and WriteAddress hold their last values when Write=0.

Decomposition:
- Shared video package holds:
  - the FSM state encoding (2-bit: IDLE=0, REQ=1, WRITE=2, DONE=3)
  - BPP/AWIDTH/PSIZE defaults, so this block and the line buffer agree.
- No sub-module is needed; a single flat FSM plus counters.
- The line buffer and this block are instantiated side by side in the video top level.

Test Plan:
1. Reset asserted mid-cycle with no clock edge -> all outputs read 0 immediately; FSM IDLE after release.
2. LineBase=0x0100, zero-wait ack, MemData=0x11,0x12,0x13,0x14 -> MemAddr 0x0100..0x0103.
   - Write in cycles 2,4,6,8 with WriteAddress 0..3 and DataOut 0x11..0x14.
   - Done in cycle 9; Busy in cycles 1..9.
3. Ack delayed 3 cycles per pixel -> MemReq and MemAddr held stable for 4 cycles each.
   - Exactly 4 Writes with the correct data; Done in cycle 21.
4. Second LineStart in cycle 4 of a fetch -> Overrun=1 in cycle 5 only.
   - Addresses and data of the first fetch are unchanged; no second fetch starts.
5. LineBase=0xFFFE -> MemAddr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. Reset asserted in REQ after 2 Writes -> MemReq=0 immediately.
   - A spurious MemAck after reset causes no Write.
   - The next LineStart (LineBase=0x0200) restarts at WriteAddress 0, MemAddr 0x0200.
